// File: rtl/upg_loader_pkg.sv
// Shared definitions for the UART upgrade loader: header codes, state encodings
// and the address bit that selects data memory over instruction memory.
package upg_loader_pkg;

  localparam logic [7:0] HDR_IMEM = 8'h00;
  localparam logic [7:0] HDR_DMEM = 8'h01;
  localparam logic [7:0] HDR_END  = 8'hFF;

  localparam int TGT_BIT = 14;

  typedef enum logic [2:0] {
    LD_HDR  = 3'd0,
    LD_LEN0 = 3'd1,
    LD_LEN1 = 3'd2,
    LD_DATA = 3'd3,
    LD_DONE = 3'd4
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Oversized section lengths are limited to the memory capacity.
  function automatic logic [15:0] clamp_count(input logic [15:0] n, input int unsigned max_words);
    if ({16'd0, n} > max_words) begin
      return 16'(max_words);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling, one-cycle byte_valid or frame_err per frame.
module uart_rx
  import upg_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            byte_valid_r, frame_err_r;
  logic [7:0]      byte_data_r;

  // Line synchroniser and frame-sampling state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r    <= 1'b1;
      rx_sync_r    <= 1'b1;
      rx_prev_r    <= 1'b1;
      state_r      <= RX_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      rx_meta_r    <= rx;
      rx_sync_r    <= rx_meta_r;
      rx_prev_r    <= rx_sync_r;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (rx_prev_r && !rx_sync_r) begin
            state_r <= RX_START;
            cnt_r   <= '0;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            // A start bit that is high again by mid-bit was a glitch.
            state_r   <= rx_sync_r ? RX_IDLE : RX_BITS;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_BITS: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            shift_r <= {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == FULL_M1) begin
            cnt_r   <= '0;
            state_r <= RX_IDLE;
            if (rx_sync_r) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/upg_loader.sv
// Firmware upgrade loader: parses header/length/data sections from a UART byte
// stream and emits 32-bit word writes into instruction or data memory.
module upg_loader
  import upg_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int MAX_WORDS    = 16384
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        upg_rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  logic        byte_valid_s;
  logic [7:0]  byte_data_s;
  logic        frame_err_s;

  ld_state_t   state_r;
  logic        target_r;
  logic [7:0]  len_lo_r;
  logic [15:0] remaining_r;
  logic [1:0]  byte_idx_r;
  logic [23:0] word_r;
  logic [13:0] word_adr_r;
  logic        wen_r;
  logic [14:0] adr_r;
  logic [31:0] dat_r;
  logic        done_r;
  logic        err_r;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (upg_clk_i),
    .rst        (upg_rst_i),
    .rx         (upg_rx_i),
    .byte_valid (byte_valid_s),
    .byte_data  (byte_data_s),
    .frame_err  (frame_err_s)
  );

  // Section parser and word assembler; a frame error never advances the parse.
  always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
    if (upg_rst_i) begin
      state_r     <= LD_HDR;
      target_r    <= 1'b0;
      len_lo_r    <= 8'h00;
      remaining_r <= 16'd0;
      byte_idx_r  <= 2'd0;
      word_r      <= 24'h000000;
      word_adr_r  <= 14'd0;
      wen_r       <= 1'b0;
      adr_r       <= 15'd0;
      dat_r       <= 32'h00000000;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      wen_r <= 1'b0;
      if (frame_err_s) begin
        err_r <= 1'b1;
      end
      if (byte_valid_s) begin
        case (state_r)
          LD_HDR: begin
            case (byte_data_s)
              HDR_IMEM: begin
                target_r <= 1'b0;
                state_r  <= LD_LEN0;
              end
              HDR_DMEM: begin
                target_r <= 1'b1;
                state_r  <= LD_LEN0;
              end
              HDR_END: begin
                done_r  <= 1'b1;
                state_r <= LD_DONE;
              end
              default: err_r <= 1'b1;
            endcase
          end
          LD_LEN0: begin
            len_lo_r <= byte_data_s;
            state_r  <= LD_LEN1;
          end
          LD_LEN1: begin
            if ({byte_data_s, len_lo_r} == 16'd0) begin
              state_r <= LD_HDR;
            end else begin
              remaining_r <= clamp_count({byte_data_s, len_lo_r}, MAX_WORDS);
              word_adr_r  <= 14'd0;
              byte_idx_r  <= 2'd0;
              state_r     <= LD_DATA;
            end
          end
          LD_DATA: begin
            if (byte_idx_r != 2'd3) begin
              // Shift right so the first byte ends up in bits 7:0.
              word_r     <= {byte_data_s, word_r[23:8]};
              byte_idx_r <= byte_idx_r + 2'd1;
            end else begin
              wen_r                  <= 1'b1;
              dat_r                  <= {byte_data_s, word_r};
              adr_r[TGT_BIT]         <= target_r;
              adr_r[TGT_BIT-1:0]     <= word_adr_r;
              word_adr_r             <= word_adr_r + 14'd1;
              remaining_r            <= remaining_r - 16'd1;
              byte_idx_r             <= 2'd0;
              if (remaining_r == 16'd1) begin
                state_r <= LD_HDR;
              end
            end
          end
          LD_DONE: state_r <= LD_DONE;
          default: state_r <= LD_HDR;
        endcase
      end
    end
  end

  assign upg_wen_o  = wen_r;
  assign upg_adr_o  = adr_r;
  assign upg_dat_o  = dat_r;
  assign upg_done_o = done_r;
  assign upg_err_o  = err_r;

endmodule

// File: tb/tb_upg_loader.sv
// Scoreboard bench for upg_loader: stimulus pushes expected writes, a monitor
// pops and compares every write strobe.
module tb_upg_loader;

  localparam int CPB  = 4;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        wen;
  logic [14:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [46:0] sb_q[$];
  logic [7:0]  seq[$];

  always #5 clk = ~clk;

  upg_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .upg_rx_i   (rx),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL write: actual unexpected adr=%h dat=%h, required no write", adr, dat);
      end else begin
        logic [46:0] e;
        e = sb_q.pop_front();
        if ({adr, dat} !== e) begin
          bad++;
          $display("FAIL write: actual adr=%h dat=%h, required adr=%h dat=%h", adr, dat, e[46:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [14:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_dat", dat, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two imem words then end marker
    expect_write(15'h0000, 32'h12345678);
    expect_write(15'h0001, 32'hDEADBEEF);
    seq = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq();
    check("a_done_early", 32'(done), 32'd0);
    send_byte(8'hFF);
    check("a_done", 32'(done), 32'd1);
    check("a_err", 32'(err), 32'd0);
    check("a_drained", 32'(sb_q.size()), 32'd0);

    // One dmem word
    do_reset();
    expect_write(15'h4000, 32'h11223344);
    seq = '{8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF};
    send_seq();
    check("b_done", 32'(done), 32'd1);
    check("b_err", 32'(err), 32'd0);
    check("b_drained", 32'(sb_q.size()), 32'd0);

    // Bad header, then empty section and end
    do_reset();
    send_byte(8'h07);
    check("c_err_hdr", 32'(err), 32'd1);
    check("c_done_early", 32'(done), 32'd0);
    seq = '{8'h00, 8'h00, 8'h00, 8'hFF};
    send_seq();
    check("c_done", 32'(done), 32'd1);
    check("c_err", 32'(err), 32'd1);
    check("c_drained", 32'(sb_q.size()), 32'd0);

    // Framing error in the middle of a word
    do_reset();
    expect_write(15'h0000, 32'hDDCCBBAA);
    seq = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq();
    check("d_err_clean", 32'(err), 32'd0);
    send_byte(8'h55, 1'b0);
    check("d_err_frame", 32'(err), 32'd1);
    seq = '{8'hCC, 8'hDD, 8'hFF};
    send_seq();
    check("d_done", 32'(done), 32'd1);
    check("d_drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a word and of a byte
    do_reset();
    expect_write(15'h0000, 32'h04030201);
    seq = '{8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
    send_seq();
    check("e_dat_before", dat, 32'h04030201);
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("e_async_dat", dat, 32'd0);
    check("e_async_wen", 32'(wen), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("e_drained_mid", 32'(sb_q.size()), 32'd0);
    expect_write(15'h0000, 32'h04030201);
    seq = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    send_seq();
    check("e_done", 32'(done), 32'd1);
    check("e_err", 32'(err), 32'd0);
    check("e_drained", 32'(sb_q.size()), 32'd0);

    // Count 0x4001 clamps to MAXW; the extra word is parsed as header bytes
    do_reset();
    seq = '{8'h00, 8'h01, 8'h40};
    for (int k = 0; k < MAXW; k++) begin
      logic [7:0] b;
      b = 8'(8'h10 * (k + 1) + k);
      expect_write(15'(k), {b, b, b, b});
      for (int j = 0; j < 4; j++) seq.push_back(b);
    end
    seq.push_back(8'h00);
    seq.push_back(8'h00);
    seq.push_back(8'h00);
    send_seq();
    check("f_drained", 32'(sb_q.size()), 32'd0);
    check("f_done_early", 32'(done), 32'd0);
    send_byte(8'hFF);
    check("f_done", 32'(done), 32'd1);
    check("f_err", 32'(err), 32'd0);

    // Mixed sections: address restarts at 0 for each one
    do_reset();
    expect_write(15'h4000, 32'hA0A1A2A3);
    expect_write(15'h0000, 32'h0B0C0D0E);
    expect_write(15'h4000, 32'h00000001);
    expect_write(15'h4001, 32'hFFFFFFFE);
    seq = '{8'h01, 8'h01, 8'h00, 8'hA3, 8'hA2, 8'hA1, 8'hA0,
            8'h00, 8'h01, 8'h00, 8'h0E, 8'h0D, 8'h0C, 8'h0B,
            8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_seq();
    check("g_done", 32'(done), 32'd1);
    check("g_err", 32'(err), 32'd0);
    check("g_drained", 32'(sb_q.size()), 32'd0);

    // Bytes after the end marker are ignored
    send_byte(8'h00);
    send_byte(8'h01);
    check("g_done_hold", 32'(done), 32'd1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upg_loader.md
UPG_LOADER -- requirements
Module: upg_loader

Interface
REQ-001 The module SHALL take parameter CLKS_PER_BIT, default 87, meaning upg_clk_i cycles per UART bit (10 MHz / 115200).
REQ-002 The module SHALL take parameter MAX_WORDS, default 16384, meaning the word capacity of one target memory.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 upg_clk_i  input  1  UPG clock, 10 MHz; all state on its rising edge.
REQ-005 upg_rst_i  input  1  asynchronous active-high reset.
REQ-006 upg_rx_i  input  1  UART serial line: idle high, 8N1, LSB first.
REQ-007 upg_wen_o  output  1  one-cycle write strobe to instruction or data RAM.
REQ-008 upg_adr_o  output  15  bit 14 = target (0 imem, 1 dmem); bits 13:0 = word address.
REQ-009 upg_dat_o  output  32  assembled word, valid with upg_wen_o.
REQ-010 upg_done_o  output  1  programming finished; RAMs return to CPU ownership.
REQ-011 upg_err_o  output  1  sticky flag: framing error or bad header seen.

Function
REQ-012 RX SHALL synchronise upg_rx_i through 2 flops, detect a falling edge, and sample each bit at mid-bit (CLKS_PER_BIT/2 after edge, then every CLKS_PER_BIT).
REQ-013 Stop bit sampled 0 SHALL discard the byte and set upg_err_o; RX returns to idle-hunt.
REQ-014 A good byte SHALL produce a one-cycle internal byte_valid with byte_data.
REQ-015 Loader FSM states: HDR, LEN0, LEN1, DATA, DONE; reset state HDR.
REQ-016 HDR: byte 0x00 selects imem, 0x01 selects dmem -> LEN0; 0xFF -> DONE; any other -> stay HDR, set upg_err_o.
REQ-017 LEN0/LEN1 SHALL capture a 16-bit little-endian word count N; N=0 -> HDR; N>MAX_WORDS -> clamp to MAX_WORDS; else -> DATA.
REQ-018 DATA SHALL assemble 4 bytes little-endian (first byte -> bits 7:0).
REQ-019 On the 4th byte, upg_wen_o SHALL pulse high exactly 1 cycle, the cycle after that byte_valid, with upg_dat_o and upg_adr_o stable that cycle.
REQ-020 Word address SHALL start at 0 for every section, increment after each write, and wrap modulo 2^14.
REQ-021 After N writes, the FSM SHALL return to HDR; upg_adr_o/upg_dat_o hold their last values.
REQ-022 DONE SHALL drive upg_done_o=1 and ignore all further bytes until reset.
REQ-023 Multiple sections (imem and dmem, in any order, repeated) SHALL be accepted before 0xFF.
REQ-024 A framing error inside DATA SHALL NOT advance the byte index; the next good byte continues the word.

Reset
REQ-025 Reset SHALL force upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0, FSM=HDR, RX idle, and all counters=0, immediately and asynchronously.
REQ-026 Reset asserted mid-byte or mid-word SHALL discard the partial byte/word with no write strobe; the next session starts from HDR.

Structure
REQ-027 Header codes (0x00, 0x01, 0xFF), the FSM state encoding, and the target-bit index 14 SHALL live in the shared CPU package.
REQ-028 The UART receiver SHALL be a separate sub-module, uart_rx (CLKS_PER_BIT parameter; outputs byte_valid, byte_data, frame_err).

Verification (bench CLKS_PER_BIT=4)
REQ-029 Bytes 00 02 00 | 78 56 34 12 | EF BE AD DE | FF -> writes adr 0x0000 dat 0x12345678, adr 0x0001 dat 0xDEADBEEF; then upg_done_o=1, upg_err_o=0.
REQ-030 Bytes 01 01 00 | 44 33 22 11 | FF -> one write, adr 0x4000 dat 0x11223344; upg_done_o=1.
REQ-031 Header 0x07, then 00 00 00 FF -> upg_err_o=1, no writes, upg_done_o=1.
REQ-032 Byte with stop bit 0 inserted mid-word of 00 01 00 AA BB CC DD -> upg_err_o=1; one write dat 0xDDCCBBAA.
REQ-033 Reset pulsed after 2 data bytes, then 00 01 00 01 02 03 04 FF -> single write adr 0x0000 dat 0x04030201; no write before reset release.
REQ-034 Count 0x4001 followed by 16385 words -> 16384 writes with addresses 0x0000..0x3FFF; the 16385th word is parsed as header bytes, and upg_err_o reflects that parse.
